// File: rtl/fu_mem_lsu_if.sv
// Issue/completion bundle between the core and the load/store unit.
interface fu_mem_lsu_if #(
  parameter int unsigned XLEN = 32
);
  logic            en;
  logic            mem_w;
  logic [2:0]      bhw;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] mem_data;
  logic            misalign;

  // Core side: issues requests, observes the handshake and the result.
  modport master (
    output en, mem_w, bhw, rs1_data, rs2_data, imm,
    input  busy, done, mem_data, misalign
  );

  // Unit side.
  modport slave (
    input  en, mem_w, bhw, rs1_data, rs2_data, imm,
    output busy, done, mem_data, misalign
  );
endinterface

// File: rtl/fu_mem_lsu.sv
// Fixed-latency load/store functional unit with an internal byte-enabled RAM.
// An accepted op waits LATENCY edges, then touches the RAM at a single edge and
// presents a one-cycle done pulse. Misaligned or illegal ops complete with
// misalign=1 and leave the RAM untouched.
module fu_mem_lsu #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  fu_mem_lsu_if.slave lsu_io
);

  localparam int unsigned AddrW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            op_w_q, op_w_d;
  logic [2:0]      op_bhw_q, op_bhw_d;
  logic [XLEN-1:0] op_wdata_q, op_wdata_d;
  logic [XLEN-1:0] op_ea_q, op_ea_d;
  logic [XLEN-1:0] mem_data_q, mem_data_d;
  logic            misalign_q, misalign_d;

  logic            accept;
  logic            complete;
  logic            legal;
  logic            aligned;
  logic            op_ok;
  logic            ram_we;
  logic [AddrW-1:0] widx;
  logic [XLEN-1:0] rdata;
  logic [XLEN-1:0] wmask;
  logic [XLEN-1:0] wdata_lane;
  logic [XLEN-1:0] wword;
  logic [XLEN-1:0] load_val;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  logic [XLEN-1:0] ram_q [DEPTH_WORDS];

  // Address bits above the RAM depth are ignored, so addresses alias.
  logic unused_ea_hi;
  assign unused_ea_hi = ^op_ea_q[XLEN-1:AddrW+2];

  assign widx     = op_ea_q[AddrW+1:2];
  assign rdata    = ram_q[widx];
  assign ld_byte  = rdata[{op_ea_q[1:0], 3'b000} +: 8];
  assign ld_half  = op_ea_q[1] ? rdata[31:16] : rdata[15:0];
  assign op_ok    = legal & aligned;
  assign complete = (state_q == StWait) && (cnt_q == 4'd0);
  assign ram_we   = complete & op_ok & op_w_q;
  assign wword    = (rdata & ~wmask) | (wdata_lane & wmask);

  // Decode size/sign, alignment, store lane mask and load extraction.
  always_comb begin
    legal      = 1'b0;
    aligned    = 1'b1;
    wmask      = '0;
    wdata_lane = '0;
    load_val   = rdata;
    unique case (op_bhw_q)
      3'b000: begin
        legal      = 1'b1;
        wmask      = 32'h0000_00ff << {op_ea_q[1:0], 3'b000};
        wdata_lane = {4{op_wdata_q[7:0]}};
        load_val   = {{24{ld_byte[7]}}, ld_byte};
      end
      3'b001: begin
        legal      = 1'b1;
        aligned    = ~op_ea_q[0];
        wmask      = op_ea_q[1] ? 32'hffff_0000 : 32'h0000_ffff;
        wdata_lane = {2{op_wdata_q[15:0]}};
        load_val   = {{16{ld_half[15]}}, ld_half};
      end
      3'b010: begin
        legal      = 1'b1;
        aligned    = (op_ea_q[1:0] == 2'b00);
        wmask      = '1;
        wdata_lane = op_wdata_q;
        load_val   = rdata;
      end
      3'b100: begin
        legal    = ~op_w_q;
        load_val = {24'h0, ld_byte};
      end
      3'b101: begin
        legal    = ~op_w_q;
        aligned  = ~op_ea_q[0];
        load_val = {16'h0, ld_half};
      end
      default: legal = 1'b0;
    endcase
  end

  // Next-state logic: accept in IDLE/DONE, count down in WAIT, complete at zero.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_w_d     = op_w_q;
    op_bhw_d   = op_bhw_q;
    op_wdata_d = op_wdata_q;
    op_ea_d    = op_ea_q;
    mem_data_d = mem_data_q;
    misalign_d = misalign_q;
    accept     = 1'b0;
    unique case (state_q)
      StIdle: accept = lsu_io.en;
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d    = StDone;
          mem_data_d = (op_ok && !op_w_q) ? load_val : '0;
          misalign_d = ~op_ok;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        accept  = lsu_io.en;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      state_d    = StWait;
      cnt_d      = CntLoad;
      op_w_d     = lsu_io.mem_w;
      op_bhw_d   = lsu_io.bhw;
      op_wdata_d = lsu_io.rs2_data;
      op_ea_d    = lsu_io.rs1_data + lsu_io.imm;
    end
  end

  // Control and result registers; reset cancels any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_w_q     <= 1'b0;
      op_bhw_q   <= '0;
      op_wdata_q <= '0;
      op_ea_q    <= '0;
      mem_data_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_w_q     <= op_w_d;
      op_bhw_q   <= op_bhw_d;
      op_wdata_q <= op_wdata_d;
      op_ea_q    <= op_ea_d;
      mem_data_q <= mem_data_d;
      misalign_q <= misalign_d;
    end
  end

  // Data RAM: not reset; written only at the completion edge of a legal store.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[widx] <= wword;
    end
  end

  assign lsu_io.busy     = (state_q == StWait);
  assign lsu_io.done     = (state_q == StDone);
  assign lsu_io.mem_data = mem_data_q;
  assign lsu_io.misalign = misalign_q;

endmodule

// File: tb/tb_fu_mem_lsu.sv
// Bench for fu_mem_lsu: byte-array reference model with timestamped completion,
// per-cycle output comparison, directed literal checks and randomized traffic.
module tb_fu_mem_lsu;

  localparam int unsigned DW  = 256;
  localparam int unsigned LAT = 3;
  localparam int unsigned NB  = 4 * DW;

  logic clk = 1'b0;
  logic rst;

  fu_mem_lsu_if #(.XLEN(32)) bus ();

  fu_mem_lsu #(
    .XLEN       (32),
    .DEPTH_WORDS(DW),
    .LATENCY    (LAT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .lsu_io(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;
  logic chk_on = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_mem [NB];
  logic        m_inflight, m_done, m_mis, m_w;
  logic [2:0]  m_b;
  logic [31:0] m_data, m_wd, m_ea;
  int unsigned cyc, m_due;

  function automatic int unsigned size_of(input logic [2:0] b);
    return 32'd1 << b[1:0];
  endfunction

  function automatic logic bad_op(input logic w, input logic [2:0] b, input logic [31:0] ea);
    logic legal;
    if (w) legal = (b == 3'd0) || (b == 3'd1) || (b == 3'd2);
    else   legal = (b == 3'd0) || (b == 3'd1) || (b == 3'd2) || (b == 3'd4) || (b == 3'd5);
    return !legal || ((ea % size_of(b)) != 0);
  endfunction

  function automatic logic [31:0] load_of(input logic [2:0] b, input logic [31:0] ea);
    int unsigned a;
    int unsigned n;
    logic [31:0] v;
    a = ea % NB;
    n = size_of(b);
    v = 32'h0;
    for (int i = 0; i < int'(n); i++) v = v | (32'(m_mem[a + i]) << (8 * i));
    if (!b[2] && n < 4 && v[8 * n - 1]) v = v | (32'hffff_ffff << (8 * n));
    return v;
  endfunction

  // An op accepted at edge c completes at edge c+LAT; loads/stores act then.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_inflight <= 1'b0;
      m_done     <= 1'b0;
      m_data     <= 32'h0;
      m_mis      <= 1'b0;
      cyc        <= 0;
    end else begin
      cyc    <= cyc + 1;
      m_done <= 1'b0;
      if (m_inflight && cyc == m_due) begin
        m_inflight <= 1'b0;
        m_done     <= 1'b1;
        m_mis      <= bad_op(m_w, m_b, m_ea);
        m_data     <= (bad_op(m_w, m_b, m_ea) || m_w) ? 32'h0 : load_of(m_b, m_ea);
        if (!bad_op(m_w, m_b, m_ea) && m_w) begin
          m_mem[m_ea % NB] <= m_wd[7:0];
          if (size_of(m_b) >= 2) m_mem[(m_ea % NB) + 1] <= m_wd[15:8];
          if (size_of(m_b) == 4) begin
            m_mem[(m_ea % NB) + 2] <= m_wd[23:16];
            m_mem[(m_ea % NB) + 3] <= m_wd[31:24];
          end
        end
      end
      if (!m_inflight && bus.en) begin
        m_inflight <= 1'b1;
        m_due      <= cyc + LAT;
        m_w        <= bus.mem_w;
        m_b        <= bus.bhw;
        m_wd       <= bus.rs2_data;
        m_ea       <= bus.rs1_data + bus.imm;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", 32'(bus.busy), 32'(m_inflight));
      check("done", 32'(bus.done), 32'(m_done));
      check("mem_data", bus.mem_data, m_data);
      check("misalign", 32'(bus.misalign), 32'(m_mis));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic w, input logic [2:0] b, input logic [31:0] rs1,
                       input logic [31:0] imm, input logic [31:0] rs2);
    bus.mem_w    = w;
    bus.bhw      = b;
    bus.rs1_data = rs1;
    bus.imm      = imm;
    bus.rs2_data = rs2;
  endtask

  task automatic wait_done(output int e);
    int n;
    n = 0;
    while (!bus.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) check("done_timeout", 32'(bus.done), 32'd1);
    e = edge_cnt;
  endtask

  task automatic run_op(input logic w, input logic [2:0] b, input logic [31:0] rs1,
                        input logic [31:0] imm, input logic [31:0] rs2,
                        output logic [31:0] d, output logic m);
    int k, e;
    @(negedge clk);
    #1;
    drive(w, b, rs1, imm, rs2);
    bus.en = 1'b1;
    @(negedge clk);
    #1;
    bus.en = 1'b0;
    k = edge_cnt;
    wait_done(e);
    check("latency", 32'(e - k), LAT);
    d = bus.mem_data;
    m = bus.misalign;
  endtask

  logic [31:0] d;
  logic        m;
  int          k, e1, e2, extra;

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_data", bus.mem_data, 32'd0);
    check("rst_mis", 32'(bus.misalign), 32'd0);
    #1 rst = 1'b0;
    chk_on = 1'b1;

    // Give every RAM word a defined value.
    for (int w = 0; w < int'(DW); w++) run_op(1'b1, 3'd2, 32'(4 * w), 32'h0, $urandom, d, m);

    // 1: SW then LW
    run_op(1'b1, 3'd2, 32'h100, 32'h4, 32'hdead_beef, d, m);
    run_op(1'b0, 3'd2, 32'h104, 32'h0, 32'h0, d, m);
    check("t1_lw", d, 32'hdead_beef);
    check("t1_mis", 32'(m), 32'd0);

    // 2: byte store and sign/zero-extended loads
    run_op(1'b1, 3'd2, 32'h200, 32'h0, 32'h1122_3344, d, m);
    run_op(1'b1, 3'd0, 32'h200, 32'h1, 32'hffff_ff80, d, m);
    check("t2_sb_mis", 32'(m), 32'd0);
    run_op(1'b0, 3'd0, 32'h201, 32'h0, 32'h0, d, m);
    check("t2_lb", d, 32'hffff_ff80);
    run_op(1'b0, 3'd4, 32'h201, 32'h0, 32'h0, d, m);
    check("t2_lbu", d, 32'h0000_0080);
    run_op(1'b0, 3'd2, 32'h200, 32'h0, 32'h0, d, m);
    check("t2_lw", d, 32'h1122_8044);

    // 3: misaligned and illegal ops are suppressed
    run_op(1'b1, 3'd2, 32'h100, 32'h0, 32'hcafe_f00d, d, m);
    run_op(1'b1, 3'd1, 32'h100, 32'h3, 32'h0000_beef, d, m);
    check("t3_sh_mis", 32'(m), 32'd1);
    check("t3_sh_data", d, 32'h0);
    run_op(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, d, m);
    check("t3_lw_mis", 32'(m), 32'd1);
    check("t3_lw_data", d, 32'h0);
    run_op(1'b1, 3'd4, 32'h100, 32'h0, 32'h1234_5678, d, m);
    check("t3_sbu_mis", 32'(m), 32'd1);
    run_op(1'b0, 3'd2, 32'h100, 32'h0, 32'h0, d, m);
    check("t3_readback", d, 32'hcafe_f00d);
    run_op(1'b0, 3'd1, 32'h102, 32'h0, 32'h0, d, m);
    check("t3_lh", d, 32'hffff_cafe);
    run_op(1'b0, 3'd5, 32'h102, 32'h0, 32'h0, d, m);
    check("t3_lhu", d, 32'h0000_cafe);

    // 4: EN while busy is ignored; done exactly LAT edges after accept, one cycle wide
    run_op(1'b1, 3'd2, 32'h300, 32'h0, 32'h55aa_55aa, d, m);
    @(negedge clk);
    #1;
    drive(1'b0, 3'd2, 32'h104, 32'h0, 32'h0);
    bus.en = 1'b1;
    @(negedge clk);
    #1;
    k = edge_cnt;
    drive(1'b1, 3'd2, 32'h300, 32'h0, 32'hffff_ffff);
    @(negedge clk);
    #1;
    bus.en = 1'b0;
    wait_done(e1);
    check("t4_done_edge", 32'(e1 - k), LAT);
    check("t4_data", bus.mem_data, 32'hdead_beef);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    check("t4_no_extra_done", 32'(extra), 32'd0);
    run_op(1'b0, 3'd2, 32'h300, 32'h0, 32'h0, d, m);
    check("t4_ignored_store", d, 32'h55aa_55aa);

    // 5: back-to-back issue during DONE
    @(negedge clk);
    #1;
    drive(1'b0, 3'd2, 32'h104, 32'h0, 32'h0);
    bus.en = 1'b1;
    @(negedge clk);
    #1;
    k = edge_cnt;
    wait_done(e1);
    check("t5_first_lat", 32'(e1 - k), LAT);
    check("t5_first_data", bus.mem_data, 32'hdead_beef);
    #1;
    drive(1'b0, 3'd2, 32'h200, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    bus.en = 1'b0;
    wait_done(e2);
    check("t5_spacing", 32'(e2 - e1), LAT + 1);
    check("t5_second_data", bus.mem_data, 32'h1122_8044);

    // 6: reset during WAIT cancels the store; addresses alias modulo RAM size
    run_op(1'b1, 3'd2, 32'h40, 32'h0, 32'h0102_0304, d, m);
    run_op(1'b0, 3'd2, 32'h40, 32'h0, 32'h0, d, m);
    check("t6_pre", d, 32'h0102_0304);
    @(negedge clk);
    #1;
    drive(1'b1, 3'd2, 32'h40, 32'h0, 32'hffff_0000);
    bus.en = 1'b1;
    @(negedge clk);
    #1;
    bus.en = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    check("t6_rst_data", bus.mem_data, 32'h0);
    check("t6_rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    run_op(1'b0, 3'd2, 32'h40, 32'h0, 32'h0, d, m);
    check("t6_old_value", d, 32'h0102_0304);
    run_op(1'b1, 3'd2, 32'h0, 32'h8, 32'h0bad_cafe, d, m);
    run_op(1'b0, 3'd2, 32'(NB + 8), 32'h0, 32'h0, d, m);
    check("t6_alias", d, 32'h0bad_cafe);
    run_op(1'b0, 3'd2, 32'hffff_fffc, 32'hc, 32'h0, d, m);
    check("t6_wrap", d, 32'h0bad_cafe);

    // Randomized traffic, including EN spam while busy and one reset pulse.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      bus.en = ($urandom % 3) != 0;
      drive(1'($urandom % 2), 3'($urandom % 8), 32'($urandom_range(0, 255)),
            32'($urandom_range(0, 31)) - 32'd16, $urandom);
      if (($urandom % 8) == 0) bus.rs1_data = $urandom;
      if (i == 1500) rst = 1'b1;
      if (i == 1501) rst = 1'b0;
    end
    bus.en = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
